// File: rtl/risc16_pkg.sv
// Shared types and width constants for the risc16 memory arbiter slice.
//   arb_state_t : CPU run-control state (HALT holds the core in reset)
//   WORD_W      : memory data width
//   BE_W        : byte-enable width (one bit per byte of a word)
package risc16_pkg;

  typedef enum logic {ST_HALT, ST_RUN} arb_state_t;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BE_W   = 2;

endpackage

// File: rtl/risc16_mem_arbiter_sat_counter.sv
// Saturating up-counter used for the run-cycle count and host wait count.
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   clr      : synchronous clear, higher priority than inc
//   inc      : increment by one; holds once count reaches SAT
//   count    : current count value
module sat_counter #(
  parameter int unsigned    W   = 8,
  parameter logic [W-1:0]   SAT = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != SAT)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/risc16_mem_arbiter.sv
// Shares one single-port 16-bit RAM between the risc16b data bus and a
// host/loader port, and owns CPU run control (HALT keeps the core in reset).
// The CPU never stalls, so it always owns the port when it accesses memory;
// the host only gets CPU-idle cycles (every cycle while halted).
//   clk, rst            : clock, synchronous active-high reset
//   d_addr/d_oe/d_we/d_dout, d_din : CPU data bus (d_din = m_rdata)
//   h_req/h_we/h_addr/h_wdata      : host request, held until h_gnt
//   h_gnt               : combinational grant, access happens this cycle
//   h_rvalid/h_rdata    : read data pulse the cycle after a read grant
//   h_starve            : sticky, host waited WAIT_MAX cycles; cleared on grant
//   run_req/halt_req    : run-control pulses (halt wins when both set)
//   cpu_rst, running    : core reset and RUN indication
//   run_cycles          : saturating cycles-in-RUN since last HALT->RUN
//   m_addr/m_oe/m_we/m_wdata/m_rdata : memory port, combinational read
module risc16_mem_arbiter
  import risc16_pkg::*;
#(
  parameter int unsigned AW       = 16,
  parameter int unsigned WAIT_MAX = 64,
  parameter bit          BOOT_RUN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     d_addr,
  input  logic              d_oe,
  input  logic [BE_W-1:0]   d_we,
  input  logic [WORD_W-1:0] d_dout,
  output logic [WORD_W-1:0] d_din,
  input  logic              h_req,
  input  logic [BE_W-1:0]   h_we,
  input  logic [AW-1:0]     h_addr,
  input  logic [WORD_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [WORD_W-1:0] h_rdata,
  output logic              h_starve,
  input  logic              run_req,
  input  logic              halt_req,
  output logic              cpu_rst,
  output logic              running,
  output logic [31:0]       run_cycles,
  output logic [AW-1:0]     m_addr,
  output logic              m_oe,
  output logic [BE_W-1:0]   m_we,
  output logic [WORD_W-1:0] m_wdata,
  input  logic [WORD_W-1:0] m_rdata
);

  localparam arb_state_t  RST_STATE = BOOT_RUN ? ST_RUN : ST_HALT;
  localparam int unsigned WW        = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  arb_state_t    state;
  logic          run_go;
  logic          cpu_busy;
  logic          host_sel;
  logic          rvalid_q;
  logic [WW-1:0] wait_cnt;
  logic          wait_sat;

  // Run-control FSM; halt_req has priority over run_req in both states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_STATE;
    end else begin
      case (state)
        ST_HALT: if (run_req && !halt_req) state <= ST_RUN;
        ST_RUN:  if (halt_req)             state <= ST_HALT;
        default:                           state <= ST_HALT;
      endcase
    end
  end

  assign running = (state == ST_RUN);
  assign cpu_rst = rst | (state == ST_HALT);
  assign run_go  = (state == ST_HALT) && run_req && !halt_req;

  // Both sides are blocked during rst so nothing reaches memory while
  // a transaction is being abandoned.
  assign cpu_busy = running && !rst && (d_oe || (d_we != '0));
  assign host_sel = !rst && !cpu_busy && h_req;
  assign h_gnt    = host_sel;
  assign d_din    = m_rdata;

  always_comb begin
    m_addr  = d_addr;
    m_oe    = 1'b0;
    m_we    = '0;
    m_wdata = d_dout;
    if (cpu_busy) begin
      m_oe = d_oe;
      m_we = d_we;
    end else if (host_sel) begin
      m_addr  = h_addr;
      m_oe    = (h_we == '0);
      m_we    = h_we;
      m_wdata = h_wdata;
    end
  end

  // Read data captured at the edge ending the grant; h_rdata holds
  // until the next host read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      h_rdata  <= '0;
    end else begin
      rvalid_q <= host_sel && (h_we == '0);
      if (host_sel && (h_we == '0)) h_rdata <= m_rdata;
    end
  end

  // Gated so a read grant followed immediately by rst never reports data.
  assign h_rvalid = rvalid_q && !rst;

  sat_counter #(
    .W   (WW),
    .SAT (WW'(WAIT_MAX - 1))
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (h_gnt || !h_req),
    .inc   (h_req && !h_gnt),
    .count (wait_cnt)
  );

  assign wait_sat = (wait_cnt == WW'(WAIT_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      h_starve <= 1'b0;
    end else if (h_gnt) begin
      h_starve <= 1'b0;
    end else if (h_req && wait_sat) begin
      h_starve <= 1'b1;
    end
  end

  sat_counter #(
    .W   (32),
    .SAT (32'hFFFF_FFFF)
  ) u_run_cycles (
    .clk   (clk),
    .rst   (rst),
    .clr   (run_go),
    .inc   (running),
    .count (run_cycles)
  );

endmodule
